// File: rtl/fifo_piso_reader.sv
// -----------------------------------------------------------------------------
// fifo_piso_reader
//
// Read-side consumer for the PISO FIFO path. It pulls one word at a time from a
// FIFO read port that returns registered data one cycle after rd_en_o, and
// serialises the word onto a 1-bit valid/ready stream. Runs entirely in the
// FIFO read-clock domain and drives the FIFO read request directly.
//
// Parameters
//   WIDTH      data word width, must match the FIFO word width
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   CNT_WIDTH  width of the transmitted-word counter
//
// Ports
//   rd_clk      read-domain clock, all state changes on the rising edge
//   rst_i       synchronous reset, active high
//   enable_i    permits new FIFO reads; a word already started always completes
//   empty_i     FIFO empty flag
//   rdata_i     FIFO read data, valid the cycle after a read request
//   rd_en_o     FIFO read request (the only output combinational on inputs)
//   sready_i    downstream accepts the current bit
//   sdata_o     serial data bit
//   svalid_o    sdata_o is valid
//   sfirst_o    current bit is the first bit of a word
//   slast_o     current bit is the last bit of a word
//   busy_o      block is not idle
//   word_cnt_o  count of fully transmitted words, wraps
// -----------------------------------------------------------------------------
module fifo_piso_reader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 empty_i,
  input  logic [WIDTH-1:0]     rdata_i,
  output logic                 rd_en_o,
  input  logic                 sready_i,
  output logic                 sdata_o,
  output logic                 svalid_o,
  output logic                 sfirst_o,
  output logic                 slast_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o
);

  // Bit counter is at least one bit wide so WIDTH=1 still elaborates cleanly.
  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,   // FIFO read data arrives during this cycle
    SHIFT
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]  bit_cnt;

  logic in_shift;
  logic xfer;
  logic last_xfer;
  logic can_read;

  assign in_shift  = (state == SHIFT);
  assign xfer      = in_shift & sready_i;
  assign last_xfer = xfer & (bit_cnt == LAST_BIT);
  // Reset gates the request so a read is never issued while state is being
  // cleared; empty_i gating keeps the FIFO free of underflow reads.
  assign can_read  = enable_i & ~empty_i & ~rst_i;

  // Next-state and read request. A new read is only considered from IDLE or
  // on the very cycle the last bit leaves, which gives back-to-back words with
  // a single WAIT bubble between them.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_next = state;
    rd_en_o    = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_read) begin
          rd_en_o    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        if (last_xfer) begin
          rd_en_o    = can_read;
          state_next = can_read ? WAIT : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge rd_clk) begin
    if (rst_i) begin
      // A word in flight is dropped here on purpose: it has already left the
      // FIFO, is not replayed and is not counted.
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt_o <= '0;
    end else begin
      state <= state_next;
      if (state == WAIT) begin
        shreg   <= rdata_i;
        bit_cnt <= '0;
      end else if (xfer) begin
        // Shift toward the output end; vacated positions fill with zeros.
        shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (last_xfer) begin
        word_cnt_o <= word_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

  // Stream outputs decode from registered state only, so they stay stable
  // while sready_i is low.
  assign svalid_o = in_shift;
  assign sdata_o  = in_shift & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign sfirst_o = in_shift & (bit_cnt == '0);
  assign slast_o  = in_shift & (bit_cnt == LAST_BIT);
  assign busy_o   = (state != IDLE);

endmodule

// File: tb/tb_fifo_piso_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_piso_reader
//
// Directed bench for fifo_piso_reader. Two instances share one FIFO model:
// dut (MSB first, owns the FIFO read request) and dut_lsb (LSB first, same
// inputs, observed for bit ordering). Inputs change on the falling edge and
// outputs are sampled just after it.
// -----------------------------------------------------------------------------
module tb_fifo_piso_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        empty;
  logic [7:0]  rdata = 8'h00;
  logic        sready = 1'b0;

  logic        rd_en, sdata, svalid, sfirst, slast, busy;
  logic [15:0] word_cnt;
  logic        rd_en_l, sdata_l, svalid_l, sfirst_l, slast_l, busy_l;
  logic [15:0] word_cnt_l;

  int total = 0;
  int bad   = 0;
  int rd_err = 0;

  always #5 clk = ~clk;

  fifo_piso_reader #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) dut (
    .rd_clk(clk), .rst_i(rst), .enable_i(enable), .empty_i(empty),
    .rdata_i(rdata), .rd_en_o(rd_en), .sready_i(sready), .sdata_o(sdata),
    .svalid_o(svalid), .sfirst_o(sfirst), .slast_o(slast), .busy_o(busy),
    .word_cnt_o(word_cnt)
  );

  fifo_piso_reader #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_WIDTH(16)) dut_lsb (
    .rd_clk(clk), .rst_i(rst), .enable_i(enable), .empty_i(empty),
    .rdata_i(rdata), .rd_en_o(rd_en_l), .sready_i(sready), .sdata_o(sdata_l),
    .svalid_o(svalid_l), .sfirst_o(sfirst_l), .slast_o(slast_l), .busy_o(busy_l),
    .word_cnt_o(word_cnt_l)
  );

  // FIFO model: registered read data one cycle after rd_en.
  logic [7:0] mem [0:31];
  logic [4:0] wr_ptr = '0;
  logic [4:0] rd_ptr = '0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 5'd1;
    end
  end

  always @(negedge clk) begin
    if (rd_en === 1'b1 && empty === 1'b1) rd_err++;
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 5'd1;
  endtask

  task automatic test_reset;
    push(8'hA5);
    rst = 1'b1; enable = 1'b1; sready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++;
      if ({rd_en, sdata, svalid, sfirst, slast, busy} !== 6'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc%0d: got %b want 000000", c,
                 {rd_en, sdata, svalid, sfirst, slast, busy});
      end
      total++;
      if (word_cnt !== 16'd0 || word_cnt_l !== 16'd0) begin
        bad++;
        $display("FAIL reset_word_cnt: got %0d/%0d want 0", word_cnt, word_cnt_l);
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] exp;
    exp = 8'hA5;
    rst = 1'b0; sready = 1'b1;
    #1;
    total++;
    if (rd_en !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_rd_en: got rd_en=%b busy=%b want 1 0", rd_en, busy);
    end
    @(negedge clk); #1;
    total++;
    if ({rd_en, svalid, busy} !== 3'b001) begin
      bad++;
      $display("FAIL single_wait: got rd_en/svalid/busy=%b want 001", {rd_en, svalid, busy});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      total++;
      if ({svalid, sdata, sfirst, slast, rd_en} !==
          {1'b1, exp[7-i], (i == 0), (i == 7), 1'b0}) begin
        bad++;
        $display("FAIL single_bit%0d: got v/d/f/l/rd=%b want %b", i,
                 {svalid, sdata, sfirst, slast, rd_en},
                 {1'b1, exp[7-i], (i == 0), (i == 7), 1'b0});
      end
    end
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || svalid !== 1'b0 || word_cnt !== 16'd1) begin
      bad++;
      $display("FAIL single_done: got busy=%b svalid=%b cnt=%0d want 0 0 1",
               busy, svalid, word_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] rd_mask, first_mask;
    logic [15:0] stream;
    rd_mask = '0; first_mask = '0; stream = '0;
    push(8'h3C); push(8'hC3);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      rd_mask[c]    = rd_en;
      first_mask[c] = sfirst;
      if (svalid && sready) stream = {stream[14:0], sdata};
    end
    // Reads at cycle 0 (IDLE) and cycle 9 (slast of word 1); first bits at
    // cycles 2 and 11, i.e. nine cycles apart.
    total++;
    if (rd_mask !== 20'h00201) begin
      bad++;
      $display("FAIL b2b_rd_en_cycles: got %h want 00201", rd_mask);
    end
    total++;
    if (first_mask !== 20'h00804) begin
      bad++;
      $display("FAIL b2b_first_cycles: got %h want 00804", first_mask);
    end
    total++;
    if (stream !== 16'h3CC3) begin
      bad++;
      $display("FAIL b2b_stream: got %h want 3cc3", stream);
    end
    total++;
    if (word_cnt !== 16'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_count: got cnt=%0d busy=%b want 3 0", word_cnt, busy);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] stream;
    int nx, hold, shift_cycles;
    stream = '0; nx = 0; hold = 0; shift_cycles = 0;
    push(8'hF0);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      if (svalid && nx == 3 && hold < 3) begin
        sready = 1'b0;
        hold++;
      end else begin
        sready = 1'b1;
      end
      #1;
      if (svalid) shift_cycles++;
      if (svalid && sready) begin
        stream = {stream[6:0], sdata};
        nx++;
      end
      if (!sready) begin
        total++;
        if (sdata !== 1'b1 || svalid !== 1'b1 || sfirst !== 1'b0 || slast !== 1'b0) begin
          bad++;
          $display("FAIL bp_hold: got d/v/f/l=%b want 1100", {sdata, svalid, sfirst, slast});
        end
      end
    end
    sready = 1'b1;
    total++;
    if (hold !== 3 || shift_cycles !== 11) begin
      bad++;
      $display("FAIL bp_shift_len: got hold=%0d shift=%0d want 3 11", hold, shift_cycles);
    end
    total++;
    if (stream !== 8'hF0 || word_cnt !== 16'd4) begin
      bad++;
      $display("FAIL bp_stream: got %h cnt=%0d want f0 4", stream, word_cnt);
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] s_msb, s_lsb;
    s_msb = '0; s_lsb = '0;
    push(8'h01);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (svalid)   s_msb = {s_msb[6:0], sdata};
      if (svalid_l) s_lsb = {s_lsb[6:0], sdata_l};
      if (svalid_l && sfirst_l) begin
        total++;
        if (sdata_l !== 1'b1) begin
          bad++;
          $display("FAIL lsb_first_bit: got %b want 1", sdata_l);
        end
      end
    end
    total++;
    if (s_lsb !== 8'h80) begin
      bad++;
      $display("FAIL lsb_stream: got %h want 80 (bits 1,0,0,0,0,0,0,0)", s_lsb);
    end
    total++;
    if (s_msb !== 8'h01 || word_cnt_l !== 16'd5) begin
      bad++;
      $display("FAIL lsb_msb_ref: got %h cnt_l=%0d want 01 5", s_msb, word_cnt_l);
    end
  endtask

  task automatic test_reset_mid_word;
    int nx;
    nx = 0;
    push(8'hFF);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (svalid && sready) nx++;
    end
    @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    #1;
    total++;
    if (nx !== 4 || svalid !== 1'b1 || rd_en !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_pre: got nx=%0d svalid=%b rd_en=%b want 4 1 0", nx, svalid, rd_en);
    end
    @(negedge clk); #1;
    total++;
    if ({svalid, busy, sdata, svalid_l, busy_l} !== 5'b0 || word_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rstmid_clear: got v/b/d/vl/bl=%b cnt=%0d want 00000 0",
               {svalid, busy, sdata, svalid_l, busy_l}, word_cnt);
    end
    rst = 1'b0;
    push(8'h55);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++;
      if (rd_en !== 1'b0 || busy !== 1'b0 || empty !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_disabled: got rd_en=%b busy=%b empty=%b want 0 0 0",
                 rd_en, busy, empty);
      end
    end
  endtask

  task automatic test_enable_drop;
    logic [13:0] rd_mask;
    logic [7:0]  stream;
    rd_mask = '0; stream = '0;
    push(8'h12);
    enable = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 4) enable = 1'b0;
      #1;
      rd_mask[c] = rd_en;
      if (svalid && sready) stream = {stream[6:0], sdata};
    end
    total++;
    if (rd_mask !== 14'h0001) begin
      bad++;
      $display("FAIL endrop_rd_en_cycles: got %h want 0001", rd_mask);
    end
    total++;
    if (stream !== 8'h55 || word_cnt !== 16'd1 || busy !== 1'b0 || empty !== 1'b0) begin
      bad++;
      $display("FAIL endrop_result: got %h cnt=%0d busy=%b empty=%b want 55 1 0 0",
               stream, word_cnt, busy, empty);
    end
  endtask

  task automatic test_no_underflow;
    total++;
    if (rd_err !== 0) begin
      bad++;
      $display("FAIL underflow: got %0d reads while empty want 0", rd_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lsb_first();
    test_reset_mid_word();
    test_enable_drop();
    test_no_underflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_piso_reader.md
Name: fifo_piso_reader

Overview:
Read-side consumer for the PISO FIFO path. It drains words from the FIFO read port, which has one-cycle registered read data, and serialises each word onto a 1-bit stream with a valid/ready handshake. It lives in the read-clock domain and drives the FIFO's rd_en directly.

Parameters:
WIDTH, 8, data word width; must match the FIFO WIDTH.
MSB_FIRST, 1, 1 = serialise bit WIDTH-1 first, 0 = bit 0 first.
CNT_WIDTH, 16, width of the transmitted-word counter.

Ports:
rd_clk  in  1  clock; all state changes on rising edge.
rst_i  in  1  synchronous reset, active high.
enable_i  in  1  permits new FIFO reads; a word already started always completes.
empty_i  in  1  FIFO empty flag.
rdata_i  in  WIDTH  FIFO read data; valid the cycle after a read request.
rd_en_o  out  1  FIFO read request.
sready_i  in  1  downstream accepts the current bit.
sdata_o  out  1  serial data bit.
svalid_o  out  1  sdata_o is valid.
sfirst_o  out  1  current bit is the first bit of a word.
slast_o  out  1  current bit is the last bit of a word.
busy_o  out  1  block is not in IDLE.
word_cnt_o  out  CNT_WIDTH  count of fully transmitted words.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE; shift reg=0; bit_cnt=0; word_cnt_o=0.
  - rd_en_o, sdata_o, svalid_o, sfirst_o, slast_o, busy_o are all 0 in the following cycle.
  - rd_en_o is forced to 0 while rst_i=1.
- States: IDLE, WAIT, SHIFT.
- Output decode:
  - rd_en_o is the only output combinational on inputs.
  - All other outputs decode from registered state, shift reg and bit_cnt only.
- IDLE:
  - rd_en_o = enable_i & ~empty_i & ~rst_i.
  - If rd_en_o=1 at the edge, go to WAIT; otherwise stay in IDLE.
- WAIT (exactly 1 cycle):
  - rd_en_o=0.
  - At the edge, capture rdata_i into the shift reg, set bit_cnt=0, go to SHIFT.
- SHIFT:
  - svalid_o=1.
  - sdata_o = shift reg bit WIDTH-1 if MSB_FIRST=1, else bit 0.
  - sfirst_o=(bit_cnt==0); slast_o=(bit_cnt==WIDTH-1).
  - Transfer occurs at an edge where svalid_o & sready_i; on transfer, shift toward the output end and increment bit_cnt.
  - With sready_i=0: sdata_o, sfirst_o, slast_o and bit_cnt hold.
- Last-bit transfer (slast_o & sready_i):
  - word_cnt_o increments, wrapping modulo 2^CNT_WIDTH.
  - In that same cycle, rd_en_o = enable_i & ~empty_i; if 1, go to WAIT, else go to IDLE.
  - rd_en_o=0 in all other SHIFT cycles.
- Throughput and latency:
  - With sready_i=1, one word every WIDTH+1 cycles.
  - Latency from the rd_en_o cycle to the first valid bit is 1 cycle (WAIT).
- busy_o = (state != IDLE).
- Boundaries:
  - enable_i falling mid-word: the word finishes, then no further read is issued.
  - empty_i asserting mid-word: no effect until the last-bit decision.
  - Never issues rd_en_o while empty_i=1, so it cannot cause a FIFO read error.
  - Reset mid-word: the remaining bits are discarded and not replayed; the FIFO word is lost and word_cnt_o is not incremented.
  - WIDTH=1: sfirst_o and slast_o are both 1 on the single bit.

Test Plan:
1. Reset: hold rst_i=1 with enable_i=1, empty_i=0 for 3 cycles -> rd_en_o=0, all outputs 0, word_cnt_o=0.
2. Single word, MSB_FIRST=1, sready_i=1, FIFO returns 0xA5:
   - rd_en_o high for 1 cycle, then 1 WAIT cycle.
   - sdata_o=1,0,1,0,0,1,0,1 over 8 cycles; sfirst_o on bit 1, slast_o on bit 8.
   - word_cnt_o=1, then IDLE with busy_o=0.
3. Back-to-back, FIFO holds 0x3C then 0xC3:
   - rd_en_o asserted in the slast_o cycle of word 1.
   - Second word's first bit appears 9 cycles after the first word's first bit.
   - Stream is 00111100 11000011; word_cnt_o=2.
4. Backpressure on 0xF0: drop sready_i for 3 cycles while bit 4 (value 1) is presented.
   - sdata_o=1 and svalid_o=1 hold stable.
   - SHIFT lasts 11 cycles; stream unchanged.
5. MSB_FIRST=0, word 0x01 -> bits 1,0,0,0,0,0,0,0.
6. Reset mid-word:
   - Assert rst_i after the 4th bit of 0xFF -> next cycle svalid_o=0, busy_o=0, word_cnt_o=0.
   - With enable_i=0 and empty_i=0 afterwards -> rd_en_o stays 0.
